pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised program-counter stage replacing the stand-alone PC+4 adder.
- Owns the PC register and produces the sequential successor address.
- Arbitrates trap and branch/jump redirects, and presents the fetch address to instruction memory with a valid/ready handshake.
- Detects misaligned redirect targets, halts fetch on one, and counts accepted fetches for debug/perf.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be aligned to ALIGN_BITS.
- INCR, 4, sequential step added to pc (4 for RV32I; 2 reserved for compressed support).
- ALIGN_BITS, 2, number of low target bits that must be zero for a legal redirect.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold; pc does not advance.
- fetch_ready  in  1  instruction memory accepts the current pc.
- fetch_valid  out  1  pc is a valid fetch address.
- pc  out  XLEN  current fetch address (registered).
- pcplus  out  XLEN  pc + INCR, combinational from pc, modulo 2^XLEN.
- redir_valid  in  1  branch/jump redirect request.
- redir_target  in  XLEN  redirect target.
- trap_valid  in  1  trap request; overrides redirect.
- trap_vector  in  XLEN  trap handler address; low ALIGN_BITS are forced to 0.
- misalign  out  1  sticky misaligned-target flag.
- err_addr  out  XLEN  offending target captured at misalign.
- fetch_count  out  CNT_W  number of accepted fetches.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_VECTOR, state = BOOT, fetch_valid = 0.
  - misalign = 0, err_addr = 0, fetch_count = 0.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts; fetch_valid = 0.
  - Next state is RUN; pc is unchanged.
  - A trap or redirect in BOOT is applied with the same rules as RUN.
- RUN: fetch_valid = 1. Next pc, in priority order:
  1. trap_valid: pc = trap_vector with low ALIGN_BITS cleared; stay in RUN.
  2. redir_valid with redir_target[ALIGN_BITS-1:0] == 0: pc = redir_target.
  3. redir_valid with misaligned target: pc holds; misalign = 1; err_addr = redir_target; state = HALT.
  4. accept (fetch_valid & fetch_ready & !stall): pc = pcplus; fetch_count increments.
  5. Otherwise pc holds.
- Redirect and trap ignore stall and fetch_ready. Both take effect at the next rising edge (1-cycle latency).
- A same-cycle accept is still counted.
- HALT:
  - fetch_valid = 0; pc holds; redir_valid is ignored.
  - trap_valid: pc = aligned trap_vector, state = RUN. misalign stays 1 (sticky until reset).
  - err_addr holds the first error only.
- Arithmetic:
  - pcplus = pc + INCR truncated to XLEN; pc = 2^XLEN - INCR wraps to 0 with no flag.
  - fetch_count wraps modulo 2^CNT_W.
- Outputs are registered except pcplus.
- No combinational path from fetch_ready to fetch_valid.
- rst_n assertion mid-operation (any state, any cycle phase) immediately forces the reset values above.

Test Plan:
1. Release reset with fetch_ready=1, stall=0, RESET_VECTOR=0 -> fetch_valid=0 for one cycle, then pc = 0, 4, 8, 12 on consecutive cycles; pcplus = pc+4; fetch_count = 1, 2, 3 after the respective edges.
2. pc=0x10, stall=1 for 3 cycles, fetch_ready=1 -> pc stays 0x10 and fetch_count is unchanged; stall drops -> pc = 0x14 next cycle.
3. pc=0x20, redir_valid=1, redir_target=0x100, stall=1 -> pc=0x100 next cycle. Same cycle adding trap_valid=1, trap_vector=0x203 -> pc=0x200 instead.
4. redir_target=0x102 -> next cycle: misalign=1, err_addr=0x102, fetch_valid=0, pc unchanged. Further redir_valid is ignored. trap_valid with trap_vector=0x80 -> pc=0x80, fetch_valid=1, misalign stays 1.
5. pc = 32'hFFFF_FFFC accepted -> pc = 0, pcplus = 4. rst_n pulsed low mid-run -> pc = RESET_VECTOR, fetch_count = 0 and misalign = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch handshake and redirect bundle for pc_sequencer
//
// Purpose: groups the instruction-fetch handshake with the trap/redirect request lines.
// Signals:
//   fetch_valid  sequencer -> imem   pc is a valid fetch address
//   fetch_ready  imem -> sequencer   instruction memory accepts pc
//   pc           sequencer -> imem   current fetch address
//   redir_valid  pipe -> sequencer   branch/jump redirect request
//   redir_target pipe -> sequencer   redirect target
//   trap_valid   pipe -> sequencer   trap request, overrides redirect
//   trap_vector  pipe -> sequencer   trap handler address
// Modports: master = sequencer side, slave = memory/pipeline side.

interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;

  modport master (
    output fetch_valid,
    output pc,
    input  fetch_ready,
    input  redir_valid,
    input  redir_target,
    input  trap_valid,
    input  trap_vector
  );

  modport slave (
    input  fetch_valid,
    input  pc,
    output fetch_ready,
    output redir_valid,
    output redir_target,
    output trap_valid,
    output trap_vector
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter stage with trap/redirect arbitration
//
// Purpose: owns the PC register, produces the sequential successor, arbitrates
// trap over redirect, halts fetch on a misaligned redirect target and counts
// accepted fetches.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   pipeline hold; pc does not advance
//   bus          if   fetch handshake + redirect/trap requests (master modport)
//   pcplus       out  pc + INCR, combinational, modulo 2^XLEN
//   misalign     out  sticky misaligned-target flag
//   err_addr     out  first offending redirect target
//   fetch_count  out  number of accepted fetches, wraps

module pc_sequencer #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter int                INCR         = 4,
  parameter int                ALIGN_BITS   = 2,
  parameter int                CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  pc_sequencer_if.master       bus,
  output logic [XLEN-1:0]      pcplus,
  output logic                 misalign,
  output logic [XLEN-1:0]      err_addr,
  output logic [CNT_W-1:0]     fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Low-bit mask: ones above ALIGN_BITS, zeros in the bits that must be clear.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  state_t           state, state_nxt;
  logic [XLEN-1:0]  pc_q, pc_nxt;
  logic             fv_q;
  logic             mis_q, mis_nxt;
  logic [XLEN-1:0]  err_q, err_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             accept;
  logic             redir_aligned;
  logic [XLEN-1:0]  trap_aligned;

  assign pcplus        = pc_q + XLEN'(INCR);
  assign accept        = fv_q & bus.fetch_ready & ~stall;
  assign redir_aligned = (bus.redir_target & ~ALIGN_MASK) == '0;
  assign trap_aligned  = bus.trap_vector & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_VECTOR;
      fv_q  <= 1'b0;
      mis_q <= 1'b0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      // fetch_valid is a flop so fetch_ready can never reach it combinationally.
      fv_q  <= (state_nxt == RUN);
      mis_q <= mis_nxt;
      err_q <= err_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    mis_nxt   = mis_q;
    err_nxt   = err_q;
    cnt_nxt   = cnt_q;

    // An accept is counted even when a redirect or trap wins the pc update.
    if (accept) cnt_nxt = cnt_q + CNT_W'(1);

    case (state)
      BOOT, RUN: begin
        state_nxt = RUN;
        if (bus.trap_valid) begin
          pc_nxt = trap_aligned;
        end else if (bus.redir_valid && redir_aligned) begin
          pc_nxt = bus.redir_target;
        end else if (bus.redir_valid) begin
          mis_nxt   = 1'b1;
          state_nxt = HALT;
          // Only the first error is kept; misalign is sticky until reset.
          if (!mis_q) err_nxt = bus.redir_target;
        end else if (accept) begin
          pc_nxt = pcplus;
        end
      end
      HALT: begin
        if (bus.trap_valid) begin
          pc_nxt    = trap_aligned;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign bus.fetch_valid = fv_q;
  assign bus.pc          = pc_q;
  assign misalign        = mis_q;
  assign err_addr        = err_q;
  assign fetch_count     = cnt_q;

endmodule
